// File: rtl/ps2_param_entry.sv
// ps2_param_entry
//   Keyboard command front end for the step sequencer. Decodes PS/2 scan
//   code set 2 bytes (including E0-extended arrow keys and F0 break codes)
//   into committed loop count / BPM values, direction pulses and a start
//   pulse. Numeric entry is buffered in edit_value and clamped on commit.
//
// Ports
//   CLOCK_50     system clock
//   nReset       asynchronous active-low reset
//   rx_data      received scan code byte
//   rx_valid     one-cycle strobe qualifying rx_data
//   loops        committed loop count
//   bpm          committed BPM
//   dir_pulse    one-hot one-cycle {right,left,down,up}
//   start_pulse  one-cycle pulse on Space in IDLE
//   mode         0 IDLE, 1 EDIT_LOOP, 2 EDIT_BPM, 3 MOVE
//   edit_value   current edit buffer (zero-extended)
//   edit_count   number of digits in the buffer
//   blink        1 in IDLE, toggles every BLINK_TICKS cycles elsewhere
//   err_pulse    one-cycle pulse on a rejected key
module ps2_param_entry #(
  parameter int LOOP_W          = 7,
  parameter int LOOP_DIGITS     = 2,
  parameter int LOOP_MIN        = 1,
  parameter int LOOP_MAX        = 99,
  parameter int LOOP_DEFAULT    = 4,
  parameter int BPM_W           = 10,
  parameter int BPM_DIGITS      = 3,
  parameter int BPM_MIN         = 40,
  parameter int BPM_MAX         = 300,
  parameter int BPM_DEFAULT     = 120,
  parameter int BLINK_TICKS     = 12500000,
  parameter int SUPPRESS_REPEAT = 1
) (
  input  logic              CLOCK_50,
  input  logic              nReset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [LOOP_W-1:0] loops,
  output logic [BPM_W-1:0]  bpm,
  output logic [3:0]        dir_pulse,
  output logic              start_pulse,
  output logic [1:0]        mode,
  output logic [BPM_W-1:0]  edit_value,
  output logic [1:0]        edit_count,
  output logic              blink,
  output logic              err_pulse
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EDIT_LOOP = 2'd1,
    EDIT_BPM  = 2'd2,
    MOVE      = 2'd3
  } state_t;

  // Keys carry the extended flag in bit 8 so plain and E0 codes never alias.
  localparam logic [8:0] K_L     = 9'h04B;
  localparam logic [8:0] K_B     = 9'h032;
  localparam logic [8:0] K_M     = 9'h03A;
  localparam logic [8:0] K_ENTER = 9'h05A;
  localparam logic [8:0] K_SPACE = 9'h029;
  localparam logic [8:0] K_ESC   = 9'h076;
  localparam logic [8:0] K_BS    = 9'h066;
  localparam logic [8:0] K_UP    = 9'h175;
  localparam logic [8:0] K_DOWN  = 9'h172;
  localparam logic [8:0] K_LEFT  = 9'h16B;
  localparam logic [8:0] K_RIGHT = 9'h174;

  localparam logic [1:0]        LOOP_D   = 2'(LOOP_DIGITS);
  localparam logic [1:0]        BPM_D    = 2'(BPM_DIGITS);
  localparam logic [BPM_W-1:0]  LMIN_V   = BPM_W'(LOOP_MIN);
  localparam logic [BPM_W-1:0]  LMAX_V   = BPM_W'(LOOP_MAX);
  localparam logic [BPM_W-1:0]  BMIN_V   = BPM_W'(BPM_MIN);
  localparam logic [BPM_W-1:0]  BMAX_V   = BPM_W'(BPM_MAX);
  localparam int                CNT_W    = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLINK_TICKS - 1);

  // Returns {valid, value} for a digit key; non-digit keys give valid=0.
  function automatic logic [4:0] digit_of(input logic [8:0] k);
    logic [4:0] r;
    case (k)
      9'h045:  r = 5'h10;
      9'h016:  r = 5'h11;
      9'h01E:  r = 5'h12;
      9'h026:  r = 5'h13;
      9'h025:  r = 5'h14;
      9'h02E:  r = 5'h15;
      9'h036:  r = 5'h16;
      9'h03D:  r = 5'h17;
      9'h03E:  r = 5'h18;
      9'h046:  r = 5'h19;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  function automatic logic [LOOP_W-1:0] clamp_loop(input logic [BPM_W-1:0] v);
    logic [BPM_W-1:0] c;
    if (v < LMIN_V)      c = LMIN_V;
    else if (v > LMAX_V) c = LMAX_V;
    else                 c = v;
    return LOOP_W'(c);
  endfunction

  function automatic logic [BPM_W-1:0] clamp_bpm(input logic [BPM_W-1:0] v);
    logic [BPM_W-1:0] c;
    if (v < BMIN_V)      c = BMIN_V;
    else if (v > BMAX_V) c = BMAX_V;
    else                 c = v;
    return c;
  endfunction

  state_t             state, state_nxt;
  logic               brk, brk_nxt, ext, ext_nxt;
  logic [8:0]         held, held_nxt;
  logic [LOOP_W-1:0]  loops_nxt;
  logic [BPM_W-1:0]   bpm_nxt, edit_value_nxt;
  logic [1:0]         edit_count_nxt;
  logic [3:0]         dir_nxt;
  logic               start_nxt, err_nxt, blink_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;

  logic [8:0]         key;
  logic               dispatch;
  logic [4:0]         dig;
  logic [1:0]         d_max;
  logic [BPM_W+3:0]   prod;

  assign key  = {ext, rx_data};
  assign dig  = digit_of(key);
  assign prod = {4'b0, edit_value} * (BPM_W+4)'(10) + (BPM_W+4)'(dig[3:0]);
  assign mode = state;

  always_comb begin
    state_nxt      = state;
    brk_nxt        = brk;
    ext_nxt        = ext;
    held_nxt       = held;
    loops_nxt      = loops;
    bpm_nxt        = bpm;
    edit_value_nxt = edit_value;
    edit_count_nxt = edit_count;
    dir_nxt        = 4'b0000;
    start_nxt      = 1'b0;
    err_nxt        = 1'b0;
    dispatch       = 1'b0;
    d_max          = (state == EDIT_LOOP) ? LOOP_D : BPM_D;

    // Prefix bytes only arm flags; the next non-prefix byte consumes them.
    if (rx_valid) begin
      if (rx_data == 8'hF0) begin
        brk_nxt = 1'b1;
      end else if (rx_data == 8'hE0) begin
        ext_nxt = 1'b1;
      end else begin
        brk_nxt = 1'b0;
        ext_nxt = 1'b0;
        if (brk) begin
          if (key == held) held_nxt = '0;
        end else if (!(SUPPRESS_REPEAT != 0 && key == held)) begin
          held_nxt = key;
          dispatch = 1'b1;
        end
      end
    end

    case (state)
      IDLE: begin
        if (dispatch) begin
          if (key == K_L || key == K_B) begin
            state_nxt      = (key == K_L) ? EDIT_LOOP : EDIT_BPM;
            edit_value_nxt = '0;
            edit_count_nxt = 2'd0;
          end else if (key == K_M) begin
            state_nxt = MOVE;
          end else if (key == K_SPACE) begin
            start_nxt = 1'b1;
          end
        end
      end
      EDIT_LOOP, EDIT_BPM: begin
        if (dispatch) begin
          if (dig[4]) begin
            if (edit_count < d_max) begin
              edit_value_nxt = BPM_W'(prod);
              edit_count_nxt = edit_count + 2'd1;
            end else begin
              err_nxt = 1'b1;
            end
          end else if (key == K_BS) begin
            if (edit_count != 2'd0) begin
              edit_value_nxt = edit_value / BPM_W'(10);
              edit_count_nxt = edit_count - 2'd1;
            end else begin
              err_nxt = 1'b1;
            end
          end else if (key == K_ENTER || key == K_ESC) begin
            if (key == K_ENTER && edit_count != 2'd0) begin
              if (state == EDIT_LOOP) loops_nxt = clamp_loop(edit_value);
              else                    bpm_nxt   = clamp_bpm(edit_value);
            end
            state_nxt      = IDLE;
            edit_value_nxt = '0;
            edit_count_nxt = 2'd0;
          end
        end
      end
      MOVE: begin
        if (dispatch) begin
          if      (key == K_UP)    dir_nxt = 4'b0001;
          else if (key == K_DOWN)  dir_nxt = 4'b0010;
          else if (key == K_LEFT)  dir_nxt = 4'b0100;
          else if (key == K_RIGHT) dir_nxt = 4'b1000;
          else if (key == K_ENTER || key == K_ESC) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Returning to IDLE restarts the blink phase so the next edit starts lit.
    if (state_nxt == IDLE && state != IDLE) begin
      cnt_nxt   = '0;
      blink_nxt = 1'b1;
    end else begin
      cnt_nxt   = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      blink_nxt = (cnt == CNT_LAST && state != IDLE) ? ~blink : blink;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      state       <= IDLE;
      brk         <= 1'b0;
      ext         <= 1'b0;
      held        <= '0;
      loops       <= LOOP_W'(LOOP_DEFAULT);
      bpm         <= BPM_W'(BPM_DEFAULT);
      edit_value  <= '0;
      edit_count  <= 2'd0;
      dir_pulse   <= 4'b0000;
      start_pulse <= 1'b0;
      err_pulse   <= 1'b0;
      blink       <= 1'b1;
      cnt         <= '0;
    end else begin
      state       <= state_nxt;
      brk         <= brk_nxt;
      ext         <= ext_nxt;
      held        <= held_nxt;
      loops       <= loops_nxt;
      bpm         <= bpm_nxt;
      edit_value  <= edit_value_nxt;
      edit_count  <= edit_count_nxt;
      dir_pulse   <= dir_nxt;
      start_pulse <= start_nxt;
      err_pulse   <= err_nxt;
      blink       <= blink_nxt;
      cnt         <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_ps2_param_entry.sv
module tb_ps2_param_entry;

  logic        CLOCK_50 = 1'b0;
  logic        nReset   = 1'b0;
  logic [7:0]  rx_data  = 8'h00;
  logic        rx_valid = 1'b0;
  logic [6:0]  loops;
  logic [9:0]  bpm;
  logic [3:0]  dir_pulse;
  logic        start_pulse;
  logic [1:0]  mode;
  logic [9:0]  edit_value;
  logic [1:0]  edit_count;
  logic        blink;
  logic        err_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  ps2_param_entry #(.BLINK_TICKS(8)) dut (
    .CLOCK_50   (CLOCK_50),
    .nReset     (nReset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .loops      (loops),
    .bpm        (bpm),
    .dir_pulse  (dir_pulse),
    .start_pulse(start_pulse),
    .mode       (mode),
    .edit_value (edit_value),
    .edit_count (edit_count),
    .blink      (blink),
    .err_pulse  (err_pulse)
  );

  // One byte, one strobe cycle; returns 1 time unit after the sampling edge.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge CLOCK_50); #1;
    rx_valid = 1'b0;
  endtask

  task automatic release_key(input logic [7:0] b);
    send(8'hF0);
    send(b);
  endtask

  task automatic tap(input logic [7:0] b);
    send(b);
    release_key(b);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLOCK_50); #1; end
  endtask

  task automatic test_reset;
    logic any_pulse;
    nReset = 1'b0;
    #35;
    nReset = 1'b1;
    any_pulse = 1'b0;
    repeat (100) begin
      @(posedge CLOCK_50); #1;
      if (dir_pulse != 4'b0 || start_pulse || err_pulse || blink !== 1'b1) any_pulse = 1'b1;
    end
    if (loops !== 7'd4) begin $display("FAIL reset_loops: got %0d want 4", loops); n_fail++; end
    n_checks++;
    if (bpm !== 10'd120) begin $display("FAIL reset_bpm: got %0d want 120", bpm); n_fail++; end
    n_checks++;
    if (mode !== 2'd0) begin $display("FAIL reset_mode: got %0d want 0", mode); n_fail++; end
    n_checks++;
    if (edit_value !== 10'd0 || edit_count !== 2'd0) begin
      $display("FAIL reset_edit: got %0d/%0d want 0/0", edit_value, edit_count); n_fail++; end
    n_checks++;
    if (any_pulse !== 1'b0) begin $display("FAIL reset_idle_quiet: got pulse/blink glitch want none"); n_fail++; end
    n_checks++;
  endtask

  task automatic test_bpm_entry;
    send(8'h32);
    if (mode !== 2'd2 || edit_count !== 2'd0) begin
      $display("FAIL bpm_enter: got mode %0d cnt %0d want 2 0", mode, edit_count); n_fail++; end
    n_checks++;
    release_key(8'h32);
    send(8'h16);
    if (edit_value !== 10'd1 || edit_count !== 2'd1) begin
      $display("FAIL bpm_digit1: got %0d/%0d want 1/1", edit_value, edit_count); n_fail++; end
    n_checks++;
    release_key(8'h16);
    send(8'h46);
    if (edit_value !== 10'd19) begin $display("FAIL bpm_digit2: got %0d want 19", edit_value); n_fail++; end
    n_checks++;
    release_key(8'h46);
    send(8'h45);
    if (edit_value !== 10'd190 || edit_count !== 2'd3) begin
      $display("FAIL bpm_digit3: got %0d/%0d want 190/3", edit_value, edit_count); n_fail++; end
    n_checks++;
    release_key(8'h45);
    send(8'h5A);
    if (bpm !== 10'd190 || mode !== 2'd0 || edit_count !== 2'd0) begin
      $display("FAIL bpm_commit: got bpm %0d mode %0d cnt %0d want 190 0 0", bpm, mode, edit_count); n_fail++; end
    n_checks++;
    release_key(8'h5A);
  endtask

  task automatic test_clamp_and_limit;
    tap(8'h32);
    tap(8'h46); tap(8'h46); tap(8'h46);
    if (edit_value !== 10'd999) begin $display("FAIL bpm_999: got %0d want 999", edit_value); n_fail++; end
    n_checks++;
    send(8'h1E);
    if (err_pulse !== 1'b1 || edit_value !== 10'd999 || edit_count !== 2'd3) begin
      $display("FAIL digit_limit: got err %0b val %0d cnt %0d want 1 999 3", err_pulse, edit_value, edit_count); n_fail++; end
    n_checks++;
    send(8'hF0);
    if (err_pulse !== 1'b0) begin $display("FAIL err_width: got %0b want 0", err_pulse); n_fail++; end
    n_checks++;
    send(8'h1E);
    tap(8'h5A);
    if (bpm !== 10'd300 || mode !== 2'd0) begin
      $display("FAIL bpm_clamp_hi: got %0d mode %0d want 300 0", bpm, mode); n_fail++; end
    n_checks++;
    tap(8'h32);
    tap(8'h26);
    // Keypad Enter is E0 5A and must not act as Enter.
    send(8'hE0); send(8'h5A);
    if (mode !== 2'd2 || bpm !== 10'd300) begin
      $display("FAIL ext_enter_ignored: got mode %0d bpm %0d want 2 300", mode, bpm); n_fail++; end
    n_checks++;
    send(8'hE0); send(8'hF0); send(8'h5A);
    tap(8'h5A);
    if (bpm !== 10'd40) begin $display("FAIL bpm_clamp_lo: got %0d want 40", bpm); n_fail++; end
    n_checks++;
  endtask

  task automatic test_loop_edit;
    tap(8'h4B);
    if (mode !== 2'd1) begin $display("FAIL loop_enter: got %0d want 1", mode); n_fail++; end
    n_checks++;
    send(8'h66);
    if (err_pulse !== 1'b1) begin $display("FAIL bs_empty_err: got %0b want 1", err_pulse); n_fail++; end
    n_checks++;
    release_key(8'h66);
    tap(8'h1E); tap(8'h2E);
    tap(8'h66);
    if (edit_value !== 10'd2 || edit_count !== 2'd1) begin
      $display("FAIL backspace: got %0d/%0d want 2/1", edit_value, edit_count); n_fail++; end
    n_checks++;
    tap(8'h36);
    if (edit_value !== 10'd26) begin $display("FAIL loop_26: got %0d want 26", edit_value); n_fail++; end
    n_checks++;
    tap(8'h76);
    if (loops !== 7'd4 || mode !== 2'd0 || edit_count !== 2'd0) begin
      $display("FAIL esc_cancel: got loops %0d mode %0d cnt %0d want 4 0 0", loops, mode, edit_count); n_fail++; end
    n_checks++;
    tap(8'h4B); tap(8'h45); tap(8'h5A);
    if (loops !== 7'd1) begin $display("FAIL loop_clamp_lo: got %0d want 1", loops); n_fail++; end
    n_checks++;
    tap(8'h4B); tap(8'h5A);
    if (loops !== 7'd1 || mode !== 2'd0) begin
      $display("FAIL enter_empty: got loops %0d mode %0d want 1 0", loops, mode); n_fail++; end
    n_checks++;
    tap(8'h4B); tap(8'h16); tap(8'h16);
    send(8'h16);
    if (err_pulse !== 1'b1 || edit_value !== 10'd11) begin
      $display("FAIL loop_digit_limit: got err %0b val %0d want 1 11", err_pulse, edit_value); n_fail++; end
    n_checks++;
    release_key(8'h16);
    tap(8'h76);
    tap(8'h4B); tap(8'h3D); tap(8'h5A);
    if (loops !== 7'd7) begin $display("FAIL loop_commit: got %0d want 7", loops); n_fail++; end
    n_checks++;
  endtask

  task automatic test_move;
    bit seen_low;
    send(8'h16);
    if (err_pulse !== 1'b0 || mode !== 2'd0) begin
      $display("FAIL idle_digit_ignored: got err %0b mode %0d want 0 0", err_pulse, mode); n_fail++; end
    n_checks++;
    release_key(8'h16);
    tap(8'h3A);
    if (mode !== 2'd3) begin $display("FAIL move_enter: got %0d want 3", mode); n_fail++; end
    n_checks++;
    send(8'hE0); send(8'h75);
    if (dir_pulse !== 4'b0001) begin $display("FAIL dir_up: got %b want 0001", dir_pulse); n_fail++; end
    n_checks++;
    send(8'hE0);
    if (dir_pulse !== 4'b0000) begin $display("FAIL dir_up_width: got %b want 0000", dir_pulse); n_fail++; end
    n_checks++;
    send(8'hF0); send(8'h75);
    if (dir_pulse !== 4'b0000) begin $display("FAIL dir_break: got %b want 0000", dir_pulse); n_fail++; end
    n_checks++;
    send(8'hE0); send(8'h74);
    if (dir_pulse !== 4'b1000) begin $display("FAIL dir_right: got %b want 1000", dir_pulse); n_fail++; end
    n_checks++;
    send(8'hE0); send(8'h74);
    if (dir_pulse !== 4'b0000) begin $display("FAIL repeat_suppress: got %b want 0000", dir_pulse); n_fail++; end
    n_checks++;
    send(8'hE0); send(8'hF0); send(8'h74);
    seen_low = 1'b0;
    for (int i = 0; i < 20 && !seen_low; i++) begin
      @(posedge CLOCK_50); #1;
      if (blink === 1'b0) seen_low = 1'b1;
    end
    if (seen_low !== 1'b1) begin $display("FAIL blink_toggle: got no low phase in 20 cycles want toggle"); n_fail++; end
    n_checks++;
    send(8'h76);
    if (mode !== 2'd0 || blink !== 1'b1) begin
      $display("FAIL move_exit: got mode %0d blink %0b want 0 1", mode, blink); n_fail++; end
    n_checks++;
    release_key(8'h76);
  endtask

  task automatic test_start_and_async_reset;
    send(8'h29);
    if (start_pulse !== 1'b1) begin $display("FAIL start: got %0b want 1", start_pulse); n_fail++; end
    n_checks++;
    send(8'hF0);
    if (start_pulse !== 1'b0) begin $display("FAIL start_width: got %0b want 0", start_pulse); n_fail++; end
    n_checks++;
    send(8'h29);
    tap(8'h4B); tap(8'h2E);
    if (edit_count !== 2'd1 || loops !== 7'd7) begin
      $display("FAIL pre_reset: got cnt %0d loops %0d want 1 7", edit_count, loops); n_fail++; end
    n_checks++;
    #4;
    nReset = 1'b0;
    #2;
    if (loops !== 7'd4 || mode !== 2'd0 || edit_count !== 2'd0 || edit_value !== 10'd0) begin
      $display("FAIL async_reset: got loops %0d mode %0d cnt %0d val %0d want 4 0 0 0",
               loops, mode, edit_count, edit_value); n_fail++; end
    n_checks++;
    @(negedge CLOCK_50);
    nReset = 1'b1;
    idle(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_bpm_entry();
    test_clamp_and_limit();
    test_loop_edit();
    test_move();
    test_start_and_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
